// File: rtl/row_span_render_pkg.sv
// Shared definitions for the per-row wall renderer.
// Holds the default view width, the two wall colours (BBGGRR) and the
// 2-bit span FSM state encoding used by row_span_render.
package row_span_render_pkg;

  localparam int H_VIEW_DEF = 640;

  localparam logic [5:0] COL_WALL_LIGHT = 6'b11_00_00;
  localparam logic [5:0] COL_WALL_DARK  = 6'b10_00_00;
  localparam logic [5:0] COL_BLANK      = 6'b00_00_00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_IN   = 2'd2,
    ST_POST = 2'd3
  } span_state_t;

endpackage

// File: rtl/row_span_render_span_edges.sv
// span_edges: combinational wall-slice edge calculator.
// Converts a wall half-height into the left/right pixel columns of the lit
// span, centred on H_VIEW/2 and clamped to the visible line. Also used by
// the floor pass, so it carries no state.
// Ports:
//   i_size   in  SIZE_W  wall half-height (unsigned)
//   o_left   out HPOS_W  first lit column
//   o_right  out HPOS_W  last lit column
module span_edges #(
  parameter int H_VIEW = 640,
  parameter int SIZE_W = 11,
  parameter int HPOS_W = 10
) (
  input  logic [SIZE_W-1:0] i_size,
  output logic [HPOS_W-1:0] o_left,
  output logic [HPOS_W-1:0] o_right
);

  localparam int HALF = H_VIEW / 2;
  localparam logic [SIZE_W:0] HALF_X = (SIZE_W+1)'(HALF);
  localparam logic [SIZE_W:0] LAST_X = (SIZE_W+1)'(H_VIEW - 1);

  // One extra bit so HALF + size cannot wrap before the clamp.
  logic [SIZE_W:0] w_size_x;
  logic [SIZE_W:0] w_sum;

  assign w_size_x = {1'b0, i_size};
  assign w_sum    = HALF_X + w_size_x;

  always_comb begin
    o_left  = '0;
    o_right = HPOS_W'(H_VIEW - 1);
    if (w_size_x < HALF_X) begin
      o_left = HPOS_W'(HALF_X - w_size_x);
      if (w_sum < LAST_X) begin
        o_right = HPOS_W'(w_sum);
      end
    end
  end

endmodule

// File: rtl/row_span_render.sv
// row_span_render: clocked per-row wall renderer.
// Latches one wall slice (side, size) per scan line on line_start, tracks the
// beam through the lit span with a small FSM and emits registered hit/rgb and
// the pixel offset inside the span (span_x) one cycle after hpos.
// Optional build macro ROW_SPAN_RENDER_SHADE_EN: distance shading, halving
// the blue field for narrow (far) walls. Without it the output is flat
// two-colour.
// Ports:
//   clk         in   1       pixel clock
//   reset       in   1       synchronous, active-high
//   line_start  in   1       pulse in hblank; latches side_in/size_in
//   side_in     in   1       wall side for the coming line
//   size_in     in   SIZE_W  wall half-height for the coming line
//   visible     in   1       high while hpos is in 0..H_VIEW-1
//   hpos        in   HPOS_W  beam position
//   hit         out  1       pixel of previous cycle lies in span
//   rgb         out  6       colour BBGGRR, 0 when !hit
//   span_x      out  HPOS_W  offset from left edge, 0 when !hit
module row_span_render
  import row_span_render_pkg::*;
#(
  parameter int H_VIEW = H_VIEW_DEF,
  parameter int SIZE_W = 11,
  parameter int HPOS_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              side_in,
  input  logic [SIZE_W-1:0] size_in,
  input  logic              visible,
  input  logic [HPOS_W-1:0] hpos,
  output logic              hit,
  output logic [5:0]        rgb,
  output logic [HPOS_W-1:0] span_x
);

  localparam int HALF = H_VIEW / 2;

  span_state_t       r_state;
  span_state_t       w_next_state;
  logic              r_side;
  logic [SIZE_W-1:0] r_size;
  logic [HPOS_W-1:0] w_left;
  logic [HPOS_W-1:0] w_right;
  logic              w_in_span;
  logic              r_hit_p1;
  logic [5:0]        r_rgb_p1;
  logic [HPOS_W-1:0] r_span_x_p1;

`ifdef ROW_SPAN_RENDER_SHADE_EN
  // Far walls (small half-height) get the blue field dimmed to 2'b01.
  function automatic logic [5:0] wall_colour(input logic side, input logic [SIZE_W-1:0] size);
    logic [5:0] col;
    col = side ? COL_WALL_LIGHT : COL_WALL_DARK;
    if ({1'b0, size} < (SIZE_W+1)'(HALF / 4)) begin
      col[5:4] = 2'b01;
    end
    return col;
  endfunction
`else
  function automatic logic [5:0] wall_colour(input logic side);
    return side ? COL_WALL_LIGHT : COL_WALL_DARK;
  endfunction
`endif

  span_edges #(
    .H_VIEW (H_VIEW),
    .SIZE_W (SIZE_W),
    .HPOS_W (HPOS_W)
  ) u_edges (
    .i_size  (r_size),
    .o_left  (w_left),
    .o_right (w_right)
  );

  // Next state and hit decision. line_start overrides any advance that cycle
  // so a fresh slice never renders with the previous line's edges. The >=
  // compares let a beam that jumps past an edge still enter/leave the span.
  always_comb begin
    w_next_state = r_state;
    w_in_span    = 1'b0;
    if (line_start) begin
      w_next_state = ST_PRE;
    end else if (visible) begin
      case (r_state)
        ST_PRE: begin
          if (hpos >= w_left) begin
            w_in_span    = (hpos <= w_right);
            w_next_state = (hpos >= w_right) ? ST_POST : ST_IN;
          end
        end
        ST_IN: begin
          w_in_span = (hpos >= w_left) && (hpos <= w_right);
          if (hpos >= w_right) begin
            w_next_state = ST_POST;
          end
        end
        default: begin
          w_next_state = r_state;
        end
      endcase
    end
  end

  // Stage p1: registered outputs, one cycle after hpos.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_side      <= 1'b0;
      r_size      <= '0;
      r_hit_p1    <= 1'b0;
      r_rgb_p1    <= COL_BLANK;
      r_span_x_p1 <= '0;
    end else begin
      r_state  <= w_next_state;
      r_hit_p1 <= w_in_span;
      if (line_start) begin
        r_side <= side_in;
        r_size <= size_in;
      end
`ifdef ROW_SPAN_RENDER_SHADE_EN
      r_rgb_p1 <= w_in_span ? wall_colour(r_side, r_size) : COL_BLANK;
`else
      r_rgb_p1 <= w_in_span ? wall_colour(r_side) : COL_BLANK;
`endif
      r_span_x_p1 <= w_in_span ? (hpos - w_left) : '0;
    end
  end

  assign hit    = r_hit_p1;
  assign rgb    = r_rgb_p1;
  assign span_x = r_span_x_p1;

endmodule

// File: tb/tb_row_span_render.sv
// Scoreboard testbench for row_span_render: the driver computes the expected
// registered outputs from a behavioural model of a scan line and queues them;
// a monitor on the falling edge pops and compares every output cycle.
module tb_row_span_render;

  localparam int H_VIEW = 640;
  localparam int HALF   = H_VIEW / 2;

  logic        clk;
  logic        reset;
  logic        line_start;
  logic        side_in;
  logic [10:0] size_in;
  logic        visible;
  logic [9:0]  hpos;
  logic        hit;
  logic [5:0]  rgb;
  logic [9:0]  span_x;

  typedef struct {
    logic       hit;
    logic [5:0] rgb;
    logic [9:0] sx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   hit_cnt  = 0;
  int   cyc      = 0;

  // Model state: a slice is armed by line_start and consumed once the beam
  // reaches its right edge; reset discards it.
  logic        m_armed = 1'b0;
  logic        m_side  = 1'b0;
  int          m_size  = 0;

  row_span_render #(.H_VIEW(H_VIEW), .SIZE_W(11), .HPOS_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .side_in    (side_in),
    .size_in    (size_in),
    .visible    (visible),
    .hpos       (hpos),
    .hit        (hit),
    .rgb        (rgb),
    .span_x     (span_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void edges(input int size, output int l, output int r);
    if (size >= HALF) begin
      l = 0;
      r = H_VIEW - 1;
    end else begin
      l = HALF - size;
      r = (HALF + size > H_VIEW - 1) ? H_VIEW - 1 : HALF + size;
    end
  endfunction

  function automatic logic [5:0] colour(input logic side, input int size);
    logic [5:0] c;
    c = side ? 6'b11_00_00 : 6'b10_00_00;
`ifdef ROW_SPAN_RENDER_SHADE_EN
    if (size < HALF / 4) c = 6'b01_00_00;
`endif
    return c;
  endfunction

  // Apply one cycle of inputs and queue the output expected after the edge.
  task automatic drv(input logic r, input logic ls, input logic sd,
                     input int sz, input logic vs, input int hp);
    exp_t e;
    int   l, rr;
    reset      = r;
    line_start = ls;
    side_in    = sd;
    size_in    = 11'(sz);
    visible    = vs;
    hpos       = 10'(hp);
    e.hit = 1'b0; e.rgb = 6'd0; e.sx = 10'd0;
    if (r) begin
      m_armed = 1'b0; m_side = 1'b0; m_size = 0;
    end else if (ls) begin
      m_armed = 1'b1; m_side = sd; m_size = sz;
    end else if (vs && m_armed) begin
      edges(m_size, l, rr);
      if (hp >= l && hp <= rr) begin
        e.hit = 1'b1;
        e.rgb = colour(m_side, m_size);
        e.sx  = 10'(hp - l);
      end
      if (hp >= rr) m_armed = 1'b0;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic hblank(input int n, input logic ls, input logic sd, input int sz);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, (ls && i == 1), sd, sz, 1'b0, 0);
    end
  endtask

  // Monotonic sweep 0..H_VIEW-1, optionally pausing with visible low.
  task automatic sweep(input int gap_at, input int gap_len);
    for (int hp = 0; hp < H_VIEW; hp++) begin
      if (hp == gap_at) begin
        for (int g = 0; g < gap_len; g++) drv(1'b0, 1'b0, 1'b0, 0, 1'b0, hp);
      end
      drv(1'b0, 1'b0, 1'b0, 0, 1'b1, hp);
    end
  endtask

  task automatic check_count(input string name, input int want);
    n_checks++;
    if (hit_cnt != want) begin
      n_errors++;
      $display("FAIL %s: hit cycles got %0d, expected %0d", name, hit_cnt, want);
    end
  endtask

  // Monitor: one comparison per output cycle.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (hit) hit_cnt++;
      if (hit !== e.hit || rgb !== e.rgb || span_x !== e.sx) begin
        n_errors++;
        $display("FAIL scoreboard cyc %0d: got hit=%b rgb=%b span_x=%0d, expected hit=%b rgb=%b span_x=%0d",
                 cyc, hit, rgb, span_x, e.hit, e.rgb, e.sx);
      end
    end
  end

  initial begin
    int   timeout;
    logic sd;
    int   sz;
    int   hp;
    int   gl;
    reset = 1'b1; line_start = 1'b0; side_in = 1'b0; size_in = '0;
    visible = 1'b0; hpos = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);

    // No slice yet: a sweep must stay blank.
    hit_cnt = 0;
    sweep(-1, 0);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("idle_blank", 0);

    // size=100, side=1: pixels 220..420.
    hblank(4, 1'b1, 1'b1, 100);
    hit_cnt = 0;
    sweep(-1, 0);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("size100", 201);

    // size=0, side=0: single pixel at 320.
    hblank(4, 1'b1, 1'b0, 0);
    hit_cnt = 0;
    sweep(-1, 0);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("size0", 1);

    // Full-width slices.
    hblank(4, 1'b1, 1'b1, 320);
    hit_cnt = 0;
    sweep(-1, 0);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("size320", 640);
    hblank(4, 1'b1, 1'b0, 2047);
    hit_cnt = 0;
    sweep(-1, 0);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("size2047", 640);

    // No line_start: previous slice must not re-render.
    hit_cnt = 0;
    sweep(-1, 0);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("no_line_start", 0);

    // visible low 5 cycles at hpos 300, size=100.
    hblank(4, 1'b1, 1'b1, 100);
    hit_cnt = 0;
    sweep(300, 5);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("visible_gap", 201);

    // Shading sizes.
    hblank(4, 1'b1, 1'b1, 50);
    sweep(-1, 0);
    hblank(4, 1'b1, 1'b1, 100);
    sweep(-1, 0);

    // Reset held 3 cycles mid-span, then the rest of the line stays blank.
    hblank(4, 1'b1, 1'b1, 100);
    for (hp = 0; hp < 250; hp++) drv(1'b0, 1'b0, 1'b0, 0, 1'b1, hp);
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 1'b0, 0, 1'b1, hp + i);
    hit_cnt = 0;
    for (hp = 253; hp < H_VIEW; hp++) drv(1'b0, 1'b0, 1'b0, 0, 1'b1, hp);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("after_reset", 0);

    // line_start and reset together: reset wins.
    drv(1'b1, 1'b1, 1'b1, 100, 1'b0, 0);
    hit_cnt = 0;
    sweep(-1, 0);
    hblank(3, 1'b0, 1'b0, 0);
    check_count("reset_beats_ls", 0);

    // Randomised lines: gaps, jumps, mid-line line_start/reset, skipped slices.
    for (int ln = 0; ln < 40; ln++) begin
      sd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: sz = $urandom_range(0, 20);
        1: sz = $urandom_range(0, 319);
        2: sz = $urandom_range(300, 340);
        default: sz = $urandom_range(0, 2047);
      endcase
      hblank(3, ($urandom_range(0, 9) != 0), sd, sz);
      hp = 0;
      while (hp < H_VIEW) begin
        case ($urandom_range(0, 999))
          0, 1, 2: drv(1'b0, 1'b1, 1'(~sd), $urandom_range(0, 400), 1'b1, hp);
          3, 4:    drv(1'b1, 1'b0, 1'b0, 0, 1'b1, hp);
          default: begin
            if ($urandom_range(0, 99) < 2) begin
              gl = $urandom_range(1, 6);
              for (int g = 0; g < gl; g++) drv(1'b0, 1'b0, 1'b0, 0, 1'b0, hp);
            end
            drv(1'b0, 1'b0, 1'b0, 0, 1'b1, hp);
          end
        endcase
        if ($urandom_range(0, 99) == 0) hp = hp + $urandom_range(1, 60);
        else hp = hp + 1;
      end
    end
    hblank(3, 1'b0, 1'b0, 0);

    // Drain the scoreboard with a bounded wait.
    timeout = 0;
    while (exp_q.size() > 0 && timeout < 100) begin
      @(posedge clk);
      timeout++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
